operand_word_mem: RTL
=====================

Name: operand_word_mem

Overview:
- Parametrised successor to the fixed single-port operand ROMs (modulus/exponent word stores) in the ModExp datapath.
- Holds one multi-word operand as DEPTH words of DATA_WIDTH bits.
- Adds a runtime sequential load port, single-word random reads, and a streaming burst reader with valid/ready backpressure, running LSW-first or MSW-first.
- Sits between the host/loader and the Montgomery multiplier word pipeline.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 7, address width; DEPTH = 2**ADDR_WIDTH words (default 128 words = 4096 bits)

Ports:
clock  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high
load_start  in  1  begin load (accepted only in IDLE)
load_base  in  ADDR_WIDTH  first write address
load_len  in  ADDR_WIDTH  word count; 0 means DEPTH
load_valid  in  1  load_data present this cycle
load_data  in  DATA_WIDTH  word to write
load_ready  out  1  high in LOAD state
load_done  out  1  one-cycle pulse after last word written
rd_en  in  1  random read request (accepted only in IDLE)
rd_addr  in  ADDR_WIDTH  random read address
rd_valid  out  1  rd_data valid, exactly 1 cycle after accepted rd_en
rd_data  out  DATA_WIDTH  random read word
burst_start  in  1  begin stream (accepted only in IDLE)
burst_base  in  ADDR_WIDTH  first read address
burst_len  in  ADDR_WIDTH  word count; 0 means DEPTH
burst_dir  in  1  0 = ascending address, 1 = descending
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid and out_ready
out_data  out  DATA_WIDTH  streamed word
out_last  out  1  high with final word of burst
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, LOAD, STREAM.
- Start priority in IDLE, same cycle: load_start > burst_start > rd_en. Lower-priority requests are dropped, not queued.
- LOAD
  - Write pointer is set to load_base. Each cycle with load_valid=1, writes load_data, pointer +1 mod DEPTH, remaining count -1.
  - Cycles with load_valid=0 are idle.
  - After the final write: load_done=1 for one cycle, concurrently back to IDLE, load_ready=0.
- STREAM
  - Read pointer is set to burst_base; steps +1 (dir=0) or -1 (dir=1) mod DEPTH (wrap 127->0 / 0->127).
  - Memory read latency is 1 cycle. First out_valid is 2 cycles after the burst_start cycle.
  - With out_ready held high, one word per cycle, no bubbles.
  - While out_valid=1 and out_ready=0: out_data, out_last and out_valid hold stable. A 2-entry skid absorbs the in-flight read, so no word is lost or duplicated.
  - out_last=1 only on the final word. The transfer where it is accepted returns the FSM to IDLE the next cycle.
- Random read: rd_valid pulses 1 cycle after acceptance; rd_data holds the last value otherwise.
- rd_en, load_start and burst_start are ignored when busy=1.
- load_valid outside LOAD is ignored; no write occurs.
- Reset values: load_ready=0, load_done=0, rd_valid=0, rd_data=0, out_valid=0, out_data=0, out_last=0, busy=0, state IDLE, pointers/counters 0.
- Reset mid-LOAD or mid-STREAM aborts immediately; no load_done is issued. Words already written are retained; memory array is never cleared by reset.
- Memory contents after power-up are undefined (simulation: X).

Optional Feature:
Macro OPERAND_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed at write.
  - Every read (random or stream) rechecks parity.
  - On mismatch, output parity_err (1 bit, reset 0) sets sticky high with the bad word's output cycle. It clears only on reset or load_start.
  - Data is passed through unchanged.
- Undefined: no parity storage, no parity_err port, array width exactly DATA_WIDTH.

Test Plan:
- Load: base 0, len 4, words 0x11,0x22,0x33,0x44 with load_valid gap after 2nd word -> load_ready high 5 cycles, load_done pulse the cycle after 0x44 write; rd_addr 2 -> rd_valid next cycle, rd_data=0x33.
- Ascending burst: base 0, len 4, dir 0, out_ready=1 -> out_valid first at start+2, data 0x11,0x22,0x33,0x44 on consecutive cycles, out_last with 0x44, busy falls next cycle.
- Descending wrap with backpressure: base 1, len 3, dir 1, DEPTH 128 after loading addr127=0xAA -> order 0x22,0x11,0xAA; out_ready low 3 cycles mid-stream -> values held, no drop/duplicate.
- len 0 burst -> exactly 128 words streamed, out_last on 128th; load_start during STREAM ignored (busy stays 1, no write).
- Reset asserted mid-STREAM after 2 words -> next cycle all outputs 0, busy 0; subsequent rd_addr 3 returns 0x44 (contents preserved).
- Parity build: force-flip stored bit of addr 1, read addr 1 -> parity_err=1 with rd_valid, stays 1 until load_start.

Source files
------------

// File: rtl/operand_word_mem.sv
// Operand word store: sequential load, random reads (1-cycle latency), and a valid/ready burst stream (first word 2 cycles after start).
// A 2-entry skid keeps the stream lossless under backpressure. Define OPERAND_MEM_PARITY_EN for per-word even parity and the parity_err port.
module operand_word_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  burst_start,
    input  logic [ADDR_WIDTH-1:0] burst_base,
    input  logic [ADDR_WIDTH-1:0] burst_len,
    input  logic                  burst_dir,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
`ifdef OPERAND_MEM_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
`ifdef OPERAND_MEM_PARITY_EN
    localparam int MW    = DATA_WIDTH + 1;
    localparam int EW    = DATA_WIDTH + 2;
`else
    localparam int MW    = DATA_WIDTH;
    localparam int EW    = DATA_WIDTH + 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

    logic [MW-1:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         ld_cnt_q, ld_cnt_d;
    logic                  load_done_q, load_done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         iss_cnt_q, iss_cnt_d;
    logic                  dir_q, dir_d;
    logic [EW-1:0]         ent0_q, ent0_d, ent1_q, ent1_d, new_ent;
    logic [1:0]            f_cnt_q, f_cnt_d;
`ifdef OPERAND_MEM_PARITY_EN
    logic                  perr_q, perr_d;
`endif

    logic          wr_en, push, pop;
    logic [MW-1:0] wr_word, rd_word, st_word;

    function automatic logic [CW-1:0] len_ext(input logic [ADDR_WIDTH-1:0] len);
        return (len == '0) ? CW'(DEPTH) : {1'b0, len};
    endfunction

    assign rd_word = mem_q[rd_addr];
    assign st_word = mem_q[rd_ptr_q];

`ifdef OPERAND_MEM_PARITY_EN
    assign wr_word = {^load_data, load_data};
    // Stored parity makes every good word XOR-reduce to zero.
    assign new_ent = {^st_word, (iss_cnt_q == CW'(1)), st_word[DATA_WIDTH-1:0]};
`else
    assign wr_word = load_data;
    assign new_ent = {(iss_cnt_q == CW'(1)), st_word};
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        ld_cnt_d    = ld_cnt_q;
        load_done_d = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_ptr_d    = rd_ptr_q;
        iss_cnt_d   = iss_cnt_q;
        dir_d       = dir_q;
        wr_en       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
`ifdef OPERAND_MEM_PARITY_EN
        perr_d      = perr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = load_base;
                    ld_cnt_d = len_ext(load_len);
`ifdef OPERAND_MEM_PARITY_EN
                    perr_d   = 1'b0;
`endif
                end else if (burst_start) begin
                    state_d   = S_STREAM;
                    rd_ptr_d  = burst_base;
                    iss_cnt_d = len_ext(burst_len);
                    dir_d     = burst_dir;
                end else if (rd_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_word[DATA_WIDTH-1:0];
`ifdef OPERAND_MEM_PARITY_EN
                    if (^rd_word) perr_d = 1'b1;
`endif
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    ld_cnt_d = ld_cnt_q - CW'(1);
                    if (ld_cnt_q == CW'(1)) begin
                        state_d     = S_IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                pop = (f_cnt_q != 2'd0) && out_ready;
                // Issue only when the read landing next edge is guaranteed a skid slot.
                push = (iss_cnt_q != '0) && ((f_cnt_q != 2'd2) || pop);
                if (push) begin
                    rd_ptr_d  = dir_q ? rd_ptr_q - ADDR_WIDTH'(1) : rd_ptr_q + ADDR_WIDTH'(1);
                    iss_cnt_d = iss_cnt_q - CW'(1);
                end
                if (pop && ent0_q[DATA_WIDTH]) state_d = S_IDLE;
`ifdef OPERAND_MEM_PARITY_EN
                if (pop && ent0_q[DATA_WIDTH+1]) perr_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        f_cnt_d = f_cnt_q;
        case ({push, pop})
            2'b10: begin
                if (f_cnt_q == 2'd0) ent0_d = new_ent;
                else                 ent1_d = new_ent;
                f_cnt_d = f_cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                f_cnt_d = f_cnt_q - 2'd1;
            end
            2'b11: begin
                if (f_cnt_q == 2'd1) begin
                    ent0_d = new_ent;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            ld_cnt_q    <= '0;
            load_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_ptr_q    <= '0;
            iss_cnt_q   <= '0;
            dir_q       <= 1'b0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            f_cnt_q     <= 2'd0;
`ifdef OPERAND_MEM_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            ld_cnt_q    <= ld_cnt_d;
            load_done_q <= load_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_ptr_q    <= rd_ptr_d;
            iss_cnt_q   <= iss_cnt_d;
            dir_q       <= dir_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            f_cnt_q     <= f_cnt_d;
`ifdef OPERAND_MEM_PARITY_EN
            perr_q      <= perr_d;
`endif
        end
    end

    // Array is deliberately outside reset: contents survive an aborted load or stream.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) mem_q[wr_ptr_q] <= wr_word;
    end

    assign load_ready = (state_q == S_LOAD);
    assign load_done  = load_done_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign out_valid  = (f_cnt_q != 2'd0);
    assign out_data   = ent0_q[DATA_WIDTH-1:0];
    assign out_last   = out_valid && ent0_q[DATA_WIDTH];
    assign busy       = (state_q != S_IDLE);
`ifdef OPERAND_MEM_PARITY_EN
    assign parity_err = perr_q || (out_valid && ent0_q[DATA_WIDTH+1]);
`endif

endmodule
